// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer core.
// Runs a session of N_ROUNDS trials. Each trial waits a pseudo-random number
// of ticks, then lights led_go and measures the reaction in ticks. The core
// reports false starts and timeouts, and keeps the last, best and average
// results for an external display block.
module reaction_timer_multi #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int N_ROUNDS     = 4,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_BITS   = 10,
    parameter int TIMEOUT_MS   = 9999,
    parameter int CNT_W        = 14
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             BTN_START,
    input  logic             BTN_REACT,
    output logic             led_go,
    output logic [CNT_W-1:0] last_ms,
    output logic [CNT_W-1:0] best_ms,
    output logic [CNT_W-1:0] avg_ms,
    output logic [3:0]       round_idx,
    output logic             false_start,
    output logic             timeout,
    output logic             done,
    output logic [2:0]       state_o
);

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int DIV_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LOG2N  = $clog2(N_ROUNDS);
    localparam int SUM_W  = CNT_W + 4;
    localparam int WAIT_W = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS)) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_GO    = 3'd2,
        ST_SHOW  = 3'd3,
        ST_FAULT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Next LFSR value: taps 16/14/13/11, shifting towards bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

    logic [1:0]        start_sync_r;
    logic [1:0]        react_sync_r;
    logic              start_prev_r;
    logic              react_prev_r;
    logic              start_p_r;
    logic              react_p_r;
    logic [DIV_W-1:0]  div_r;
    logic              tick_s;
    logic [15:0]       lfsr_r;
    logic [WAIT_W-1:0] wait_sample_s;
    logic [WAIT_W-1:0] wait_tgt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              wait_hit_s;
    logic [CNT_W-1:0]  rt_cnt_r;
    logic              rt_limit_s;
    logic [SUM_W-1:0]  sum_r;
    logic              best_pend_r;
    state_t            state_r;
    logic              led_go_r;
    logic [CNT_W-1:0]  last_r;
    logic [CNT_W-1:0]  best_r;
    logic [CNT_W-1:0]  avg_r;
    logic [3:0]        round_r;
    logic              false_start_r;
    logic              timeout_r;
    logic              done_r;

    assign tick_s        = (div_r == DIV_W'(DIV - 1));
    assign wait_sample_s = WAIT_W'(MIN_DELAY_MS) + WAIT_W'(lfsr_r[DELAY_BITS-1:0]);
    assign wait_hit_s    = ((wait_cnt_r + WAIT_W'(1)) == wait_tgt_r);
    assign rt_limit_s    = (rt_cnt_r == CNT_W'(TIMEOUT_MS - 1));

    // Synchronise both buttons and turn their rising edges into one-cycle pulses.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            start_sync_r <= 2'b00;
            react_sync_r <= 2'b00;
            start_prev_r <= 1'b0;
            react_prev_r <= 1'b0;
            start_p_r    <= 1'b0;
            react_p_r    <= 1'b0;
        end else begin
            start_sync_r <= {start_sync_r[0], BTN_START};
            react_sync_r <= {react_sync_r[0], BTN_REACT};
            start_prev_r <= start_sync_r[1];
            react_prev_r <= react_sync_r[1];
            start_p_r    <= start_sync_r[1] & ~start_prev_r;
            react_p_r    <= react_sync_r[1] & ~react_prev_r;
        end
    end

    // Free-running tick divider and LFSR; neither is disturbed by round events.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_r  <= '0;
            lfsr_r <= 16'hACE1;
        end else begin
            div_r  <= tick_s ? '0 : (div_r + DIV_W'(1));
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Session state machine with its registered results and status flags.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_r       <= ST_IDLE;
            wait_tgt_r    <= '0;
            wait_cnt_r    <= '0;
            rt_cnt_r      <= '0;
            sum_r         <= '0;
            best_pend_r   <= 1'b0;
            led_go_r      <= 1'b0;
            last_r        <= '0;
            best_r        <= '0;
            avg_r         <= '0;
            round_r       <= 4'd0;
            false_start_r <= 1'b0;
            timeout_r     <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            // best follows last_ms one cycle after a round completes
            if (best_pend_r) begin
                best_pend_r <= 1'b0;
                if (last_r < best_r) begin
                    best_r <= last_r;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_p_r) begin
                        state_r    <= ST_ARM;
                        round_r    <= 4'd0;
                        sum_r      <= '0;
                        timeout_r  <= 1'b0;
                        last_r     <= '0;
                        avg_r      <= '0;
                        best_r     <= '1;
                        wait_tgt_r <= wait_sample_s;
                        wait_cnt_r <= '0;
                    end
                end
                ST_ARM: begin
                    // a press wins over a wait that expires in the same cycle
                    if (react_p_r) begin
                        state_r       <= ST_FAULT;
                        false_start_r <= 1'b1;
                    end else if (tick_s) begin
                        if (wait_hit_s) begin
                            state_r  <= ST_GO;
                            led_go_r <= 1'b1;
                            rt_cnt_r <= '0;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                        end
                    end
                end
                ST_GO: begin
                    // a press on the final tick counts as a normal reaction
                    if (react_p_r) begin
                        state_r     <= ST_SHOW;
                        led_go_r    <= 1'b0;
                        last_r      <= rt_cnt_r;
                        sum_r       <= sum_r + SUM_W'(rt_cnt_r);
                        best_pend_r <= 1'b1;
                    end else if (tick_s) begin
                        if (rt_limit_s) begin
                            state_r     <= ST_SHOW;
                            led_go_r    <= 1'b0;
                            last_r      <= CNT_W'(TIMEOUT_MS);
                            sum_r       <= sum_r + SUM_W'(TIMEOUT_MS);
                            timeout_r   <= 1'b1;
                            best_pend_r <= 1'b1;
                        end else begin
                            rt_cnt_r <= rt_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_SHOW: begin
                    if (start_p_r) begin
                        if (round_r == 4'(N_ROUNDS - 1)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            avg_r   <= CNT_W'(sum_r >> LOG2N);
                        end else begin
                            state_r    <= ST_ARM;
                            round_r    <= round_r + 4'd1;
                            wait_tgt_r <= wait_sample_s;
                            wait_cnt_r <= '0;
                        end
                    end
                end
                ST_FAULT: begin
                    // retry the same round with a fresh random wait
                    if (start_p_r) begin
                        state_r       <= ST_ARM;
                        false_start_r <= 1'b0;
                        wait_tgt_r    <= wait_sample_s;
                        wait_cnt_r    <= '0;
                    end
                end
                ST_DONE: begin
                    if (start_p_r) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    led_go_r      <= 1'b0;
                    false_start_r <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    assign led_go      = led_go_r;
    assign last_ms     = last_r;
    assign best_ms     = best_r;
    assign avg_ms      = avg_r;
    assign round_idx   = round_r;
    assign false_start = false_start_r;
    assign timeout     = timeout_r;
    assign done        = done_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Bench for reaction_timer_multi: a cycle-level behavioural model of the
// session rules is compared against the outputs every cycle, with directed
// scenarios pinned by literal expectations and randomized sessions after them.
module tb_reaction_timer_multi;

    localparam int P_CLK_HZ = 10_000;
    localparam int P_TICK   = 1000;
    localparam int P_N      = 4;
    localparam int P_MIN    = 5;
    localparam int P_DB     = 3;
    localparam int P_TO     = 50;
    localparam int P_CW     = 14;
    localparam int DIV      = P_CLK_HZ / P_TICK;

    localparam int S_IDLE = 0, S_ARM = 1, S_GO = 2, S_SHOW = 3, S_FAULT = 4, S_DONE = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_start = 1'b0;
    logic btn_react = 1'b0;
    logic            led_go;
    logic [P_CW-1:0] last_ms;
    logic [P_CW-1:0] best_ms;
    logic [P_CW-1:0] avg_ms;
    logic [3:0]      round_idx;
    logic            false_start;
    logic            timeout;
    logic            done;
    logic [2:0]      state_o;

    reaction_timer_multi #(
        .CLK_HZ(P_CLK_HZ), .TICK_HZ(P_TICK), .N_ROUNDS(P_N),
        .MIN_DELAY_MS(P_MIN), .DELAY_BITS(P_DB), .TIMEOUT_MS(P_TO), .CNT_W(P_CW)
    ) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .BTN_START(btn_start), .BTN_REACT(btn_react),
        .led_go(led_go), .last_ms(last_ms), .best_ms(best_ms), .avg_ms(avg_ms),
        .round_idx(round_idx), .false_start(false_start), .timeout(timeout),
        .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int m_state, m_last, m_best, m_avg, m_round, m_sum;
    int m_tgt, m_waited, m_rt, ncyc, m_arm_edge, m_lfsr;
    bit m_timeout, m_best_due;
    bit [4:0] s_hist, r_hist;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lfsr_adv(input int v);
        int b;
        b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return ((v >> 1) | (b << 15)) & 32'hFFFF;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_last = 0; m_best = 0; m_avg = 0; m_round = 0; m_sum = 0;
        m_tgt = 0; m_waited = 0; m_rt = 0; ncyc = 0; m_arm_edge = 0;
        m_lfsr = 32'hACE1; m_timeout = 1'b0; m_best_due = 1'b0;
        s_hist = 5'b0; r_hist = 5'b0;
    endtask

    task automatic arm_enter();
        m_state    = S_ARM;
        m_tgt      = P_MIN + (m_lfsr % (1 << P_DB));
        m_waited   = 0;
        m_arm_edge = ncyc;
    endtask

    task automatic finish_round(input int v);
        m_last     = v;
        m_sum      = m_sum + v;
        m_state    = S_SHOW;
        m_best_due = 1'b1;
    endtask

    // one clock edge of the session rules; buttons are seen 3 edges late
    task automatic model_step();
        bit tk, sp, rp;
        if (rst_n === 1'b0) return;
        ncyc++;
        tk = ((ncyc % DIV) == 0);
        s_hist = {s_hist[3:0], btn_start};
        r_hist = {r_hist[3:0], btn_react};
        sp = s_hist[3] & ~s_hist[4];
        rp = r_hist[3] & ~r_hist[4];
        if (m_best_due) begin
            if (m_last < m_best) m_best = m_last;
            m_best_due = 1'b0;
        end
        case (m_state)
            S_IDLE: if (sp) begin
                m_round = 0; m_sum = 0; m_timeout = 1'b0; m_last = 0; m_avg = 0;
                m_best = (1 << P_CW) - 1;
                arm_enter();
            end
            S_ARM: begin
                if (rp) m_state = S_FAULT;
                else if (tk) begin
                    m_waited++;
                    if (m_waited == m_tgt) begin
                        m_state = S_GO;
                        m_rt = 0;
                    end
                end
            end
            S_GO: begin
                if (rp) finish_round(m_rt);
                else if (tk) begin
                    m_rt++;
                    if (m_rt == P_TO) begin
                        finish_round(P_TO);
                        m_timeout = 1'b1;
                    end
                end
            end
            S_SHOW: if (sp) begin
                if (m_round == P_N - 1) begin
                    m_state = S_DONE;
                    m_avg   = m_sum / P_N;
                end else begin
                    m_round++;
                    arm_enter();
                end
            end
            S_FAULT: if (sp) arm_enter();
            S_DONE:  if (sp) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    // compare every output against the model each cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_led_go", led_go, (m_state == S_GO));
            chk("cyc_state", state_o, m_state);
            chk("cyc_last", last_ms, m_last);
            chk("cyc_best", best_ms, m_best);
            chk("cyc_avg", avg_ms, m_avg);
            chk("cyc_round", round_idx, m_round);
            chk("cyc_false_start", false_start, (m_state == S_FAULT));
            chk("cyc_timeout", timeout, m_timeout);
            chk("cyc_done", done, (m_state == S_DONE));
        end
    end

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1; adv(2); btn_start = 1'b0; adv(2);
    endtask

    task automatic press_react();
        btn_react = 1'b1; adv(2); btn_react = 1'b0; adv(2);
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int k;
        k = 0;
        while (m_state != s && k < budget) begin
            adv(1);
            k++;
        end
        if (m_state != s) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_%s state=%0d expected=%0d after %0d cycles", nm, m_state, s, budget);
        end
    endtask

    // called right after the GO entry edge: react pulse lands n ticks later
    task automatic react_after(input int n);
        adv(DIV * n - 1);
        press_react();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int guard;
        model_reset();
        cmp_en = 1'b1;
        adv(3);
        chk("rst_state", state_o, 0);
        chk("rst_led", led_go, 0);
        chk("rst_best", best_ms, 0);
        chk("rst_last", last_ms, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        adv(5);

        // session A: a 20-tick reaction, then reset in the middle of GO
        press_start();
        chk("a_arm", state_o, 1);
        wait_state(S_GO, 200, "a_go0");
        chk("a_led", led_go, 1);
        react_after(20);
        chk("a_last20", last_ms, 20);
        chk("a_show", state_o, 3);
        adv(1);
        chk("a_best20", best_ms, 20);
        press_start();
        wait_state(S_GO, 200, "a_go1");
        adv(37);
        #2 rst_n = 1'b0;
        #1;
        chk("a_rst_led", led_go, 0);
        chk("a_rst_state", state_o, 0);
        chk("a_rst_last", last_ms, 0);
        chk("a_rst_best", best_ms, 0);
        chk("a_rst_round", round_idx, 0);
        model_reset();
        adv(3);
        rst_n = 1'b1;
        adv(3);

        // session B: 12, false start in round 1, then 30, 8, 18
        press_start();
        wait_state(S_GO, 200, "b_go0");
        react_after(12);
        press_start();
        adv(3);
        press_react();
        chk("b_fs", false_start, 1);
        chk("b_fs_round", round_idx, 1);
        chk("b_fs_state", state_o, 4);
        press_start();
        wait_state(S_GO, 200, "b_go1");
        react_after(30);
        press_start();
        wait_state(S_GO, 200, "b_go2");
        react_after(8);
        press_start();
        wait_state(S_GO, 200, "b_go3");
        react_after(18);
        chk("b_last18", last_ms, 18);
        adv(1);
        press_start();
        chk("b_done", done, 1);
        chk("b_avg", avg_ms, 17);
        chk("b_best", best_ms, 8);
        chk("b_round", round_idx, 3);
        chk("b_to", timeout, 0);
        press_start();
        chk("b_idle", state_o, 0);

        // session C: coincident events, timeout, held react button
        press_start();
        e = ((m_arm_edge / DIV) + m_tgt) * DIV;
        adv(e - 4 - ncyc);
        press_react();
        chk("c_coinc_state", state_o, 4);
        chk("c_coinc_led", led_go, 0);
        press_start();
        wait_state(S_GO, 200, "c_go0");
        adv(P_TO * DIV - 4);
        press_react();
        chk("c_last49", last_ms, 49);
        chk("c_to0", timeout, 0);
        chk("c_show0", state_o, 3);
        press_start();
        wait_state(S_GO, 200, "c_go1");
        wait_state(S_SHOW, 600, "c_timeout");
        chk("c_last50", last_ms, 50);
        chk("c_to1", timeout, 1);
        press_start();
        wait_state(S_GO, 200, "c_go2");
        adv(100);
        btn_react = 1'b1;
        wait_state(S_SHOW, 50, "c_hold");
        chk("c_last10", last_ms, 10);
        press_start();
        adv(30);
        chk("c_hold_nofs", false_start, 0);
        chk("c_hold_arm", state_o, 1);
        btn_react = 1'b0;
        wait_state(S_GO, 200, "c_go3");
        react_after(5);
        chk("c_last5", last_ms, 5);
        adv(1);
        press_start();
        chk("c_done", done, 1);
        chk("c_avg", avg_ms, 28);
        chk("c_best", best_ms, 5);
        chk("c_to_done", timeout, 1);
        press_start();

        // randomized sessions against the model
        for (int s = 0; s < 3; s++) begin
            adv($urandom_range(0, 20));
            press_start();
            guard = 0;
            while (m_state != S_DONE && guard < 200) begin
                guard++;
                case (m_state)
                    S_ARM: begin
                        if ($urandom_range(0, 4) == 0) begin
                            adv($urandom_range(1, 40));
                            press_react();
                        end else begin
                            wait_state(S_GO, 200, "d_go");
                        end
                    end
                    S_GO: begin
                        adv($urandom_range(1, 600));
                        if (m_state == S_GO) press_react();
                    end
                    S_SHOW, S_FAULT: begin
                        adv($urandom_range(0, 10));
                        press_start();
                    end
                    default: adv(1);
                endcase
            end
            chk("d_done", done, 1);
            press_start();
        end

        adv(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
